// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline hazard logic.
// Holds forward-select codes, memory-wait FSM encoding and a register-match helper.
// No timing of its own: it contains only types, constants and a pure function.
package mips_pkg;

  // ALU operand source selects in E.
  localparam logic [1:0] FWD_RF  = 2'b00;  // register file value
  localparam logic [1:0] FWD_WB  = 2'b01;  // result being written back in W
  localparam logic [1:0] FWD_MEM = 2'b10;  // ALU result sitting in M

  typedef enum logic [1:0] {
    MW_IDLE = 2'b00,
    MW_WAIT = 2'b01,
    MW_ERR  = 2'b10
  } mw_state_e;

  // A producer matches a consumer only if it actually writes and the
  // register is not $zero, which is hardwired and never needs forwarding.
  function automatic logic reg_hit(input logic [4:0] src, input logic [4:0] dst,
                                   input logic we);
    return we && (src != 5'd0) && (src == dst);
  endfunction

endpackage

// File: rtl/hazard_unit_if.sv
// Bundle of per-stage control/register inputs and the hazard-resolution outputs.
// Purely wiring: no latency. The pipeline (master) drives the inputs, the
// hazard unit (slave) drives forward selects, stall/flush enables and counters.
interface hazard_unit_if;
  logic [4:0]  rsD, rtD, rsE, rtE;
  logic [4:0]  WriteRegE, WriteRegM, WriteRegW;
  logic        RegWriteE, RegWriteM, RegWriteW;
  logic        MemtoRegE, MemtoRegM;
  logic        BranchD, JumpD, PCSrcD;
  logic        MemReqM, mem_ready;

  logic [1:0]  ForwardAE, ForwardBE;
  logic        ForwardAD, ForwardBD;
  logic        StallF, StallD, StallE, StallM;
  logic        FlushD, FlushE, FlushW;
  logic        mem_timeout;
  logic [31:0] stall_cycles, flush_cycles;

  modport master (
    output rsD, rtD, rsE, rtE, WriteRegE, WriteRegM, WriteRegW,
           RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM,
           BranchD, JumpD, PCSrcD, MemReqM, mem_ready,
    input  ForwardAE, ForwardBE, ForwardAD, ForwardBD,
           StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
           mem_timeout, stall_cycles, flush_cycles
  );

  modport slave (
    input  rsD, rtD, rsE, rtE, WriteRegE, WriteRegM, WriteRegW,
           RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM,
           BranchD, JumpD, PCSrcD, MemReqM, mem_ready,
    output ForwardAE, ForwardBE, ForwardAD, ForwardBD,
           StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
           mem_timeout, stall_cycles, flush_cycles
  );
endinterface

// File: rtl/mem_wait_fsm.sv
// Data-memory wait tracker with a sticky timeout after MAX_WAIT missed cycles.
// memstall is combinational from inputs and state; state updates on clka.
// Stalls while an access is outstanding and forever once ERR is reached (until rst).
// Ports: clka, rst (async active-low), MemReqM, mem_ready -> memstall, mem_timeout.
module mem_wait_fsm
  import mips_pkg::*;
#(
  parameter int MAX_WAIT = 16
) (
  input  logic clka,
  input  logic rst,
  input  logic MemReqM,
  input  logic mem_ready,
  output logic memstall,
  output logic mem_timeout
);

  localparam int              CNT_W   = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);

  mw_state_e        state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0] cnt_inc;
  logic             miss;

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    miss       = MemReqM && !mem_ready;
    cnt_inc    = wait_cnt_q + CNT_W'(1);
    case (state_q)
      MW_IDLE: begin
        // A hit in the first M cycle never leaves IDLE.
        if (miss) begin
          wait_cnt_d = CNT_W'(1);
          state_d    = (MAX_CNT <= CNT_W'(1)) ? MW_ERR : MW_WAIT;
        end
      end
      MW_WAIT: begin
        // Dropped request means the access was flushed; abandon the wait.
        if (!MemReqM || mem_ready) begin
          wait_cnt_d = '0;
          state_d    = MW_IDLE;
        end else begin
          wait_cnt_d = cnt_inc;
          if (cnt_inc >= MAX_CNT) state_d = MW_ERR;
        end
      end
      MW_ERR: begin
        state_d = MW_ERR;
      end
      default: begin
        wait_cnt_d = '0;
        state_d    = MW_IDLE;
      end
    endcase
  end

  always_ff @(posedge clka or negedge rst) begin
    if (!rst) begin
      state_q    <= MW_IDLE;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign mem_timeout = (state_q == MW_ERR);
  assign memstall    = miss || mem_timeout;

endmodule

// File: rtl/hazard_unit.sv
// Five-stage MIPS hazard resolver: forwarding selects, stall/flush enables, mem-wait FSM.
// Zero latency: all enables are combinational from inputs and FSM state; counters tick on clka.
// Memory stalls freeze F..M and bubble W; load-use/branch stalls freeze F/D and bubble E.
// Ports: clka, rst (async active-low), hz (hazard_unit_if.slave). Parameter MAX_WAIT.
// Optional HAZARD_PERF_CNT_EN adds saturating stall/flush cycle counters; otherwise they read 0.
module hazard_unit
  import mips_pkg::*;
#(
  parameter int MAX_WAIT = 16
) (
  input  logic          clka,
  input  logic          rst,
  hazard_unit_if.slave  hz
);

  logic memstall, mem_timeout;
  logic lwstall, branchstall;
  logic [1:0] fwd_ae, fwd_be;
  logic fwd_ad, fwd_bd;
  logic stall_f, stall_d, stall_e, stall_m;
  logic flush_d, flush_e, flush_w;

  mem_wait_fsm #(.MAX_WAIT(MAX_WAIT)) u_mem_wait (
    .clka        (clka),
    .rst         (rst),
    .MemReqM     (hz.MemReqM),
    .mem_ready   (hz.mem_ready),
    .memstall    (memstall),
    .mem_timeout (mem_timeout)
  );

  always_comb begin
    fwd_ae  = FWD_RF;
    fwd_be  = FWD_RF;
    fwd_ad  = 1'b0;
    fwd_bd  = 1'b0;
    stall_f = 1'b0;
    stall_d = 1'b0;
    stall_e = 1'b0;
    stall_m = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    flush_w = 1'b0;

    // Load result is not ready until W, so a dependent in D must wait a cycle.
    lwstall = hz.MemtoRegE &&
              (reg_hit(hz.rsD, hz.rtE, 1'b1) || reg_hit(hz.rtD, hz.rtE, 1'b1));
    // The D-stage comparator can only take forwarding from an M ALU result,
    // so an ALU producer in E or a load in M has to be waited out.
    branchstall = hz.BranchD &&
                  (reg_hit(hz.rsD, hz.WriteRegE, hz.RegWriteE) ||
                   reg_hit(hz.rtD, hz.WriteRegE, hz.RegWriteE) ||
                   reg_hit(hz.rsD, hz.WriteRegM, hz.MemtoRegM) ||
                   reg_hit(hz.rtD, hz.WriteRegM, hz.MemtoRegM));

    // Everything is forced quiet while reset is held, even forwards.
    if (rst) begin
      if (reg_hit(hz.rsE, hz.WriteRegM, hz.RegWriteM))      fwd_ae = FWD_MEM;
      else if (reg_hit(hz.rsE, hz.WriteRegW, hz.RegWriteW)) fwd_ae = FWD_WB;
      if (reg_hit(hz.rtE, hz.WriteRegM, hz.RegWriteM))      fwd_be = FWD_MEM;
      else if (reg_hit(hz.rtE, hz.WriteRegW, hz.RegWriteW)) fwd_be = FWD_WB;
      fwd_ad = reg_hit(hz.rsD, hz.WriteRegM, hz.RegWriteM);
      fwd_bd = reg_hit(hz.rtD, hz.WriteRegM, hz.RegWriteM);

      // Lower-priority hazards are simply deferred; they re-evaluate once
      // the higher-priority condition clears.
      if (memstall) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        stall_e = 1'b1;
        stall_m = 1'b1;
        flush_w = 1'b1;
      end else if (lwstall || branchstall) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        flush_e = 1'b1;
      end else if (hz.PCSrcD || hz.JumpD) begin
        flush_d = 1'b1;
      end
    end
  end

  assign hz.ForwardAE   = fwd_ae;
  assign hz.ForwardBE   = fwd_be;
  assign hz.ForwardAD   = fwd_ad;
  assign hz.ForwardBD   = fwd_bd;
  assign hz.StallF      = stall_f;
  assign hz.StallD      = stall_d;
  assign hz.StallE      = stall_e;
  assign hz.StallM      = stall_m;
  assign hz.FlushD      = flush_d;
  assign hz.FlushE      = flush_e;
  assign hz.FlushW      = flush_w;
  assign hz.mem_timeout = mem_timeout;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [31:0] flush_cycles_q, flush_cycles_d;

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_cycles_d = flush_cycles_q;
    if (stall_f && (stall_cycles_q != 32'hFFFF_FFFF))
      stall_cycles_d = stall_cycles_q + 32'd1;
    if ((flush_d || flush_e || flush_w) && (flush_cycles_q != 32'hFFFF_FFFF))
      flush_cycles_d = flush_cycles_q + 32'd1;
  end

  always_ff @(posedge clka or negedge rst) begin
    if (!rst) begin
      stall_cycles_q <= '0;
      flush_cycles_q <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_cycles_q <= flush_cycles_d;
    end
  end

  assign hz.stall_cycles = stall_cycles_q;
  assign hz.flush_cycles = flush_cycles_q;
`else
  assign hz.stall_cycles = 32'd0;
  assign hz.flush_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
module tb_hazard_unit;

  localparam int MAXW = 4;

  logic clka;
  logic rst;
  int   total;
  int   bad;

  hazard_unit_if hz ();

  hazard_unit #(.MAX_WAIT(MAXW)) dut (
    .clka (clka),
    .rst  (rst),
    .hz   (hz.slave)
  );

  initial clka = 1'b0;
  always #5 clka = ~clka;

  // Output vector: {FAE[1:0],FBE[1:0],FAD,FBD,SF,SD,SE,SM,FD,FE,FW,TO}
  function automatic logic [13:0] obs();
    return {hz.ForwardAE, hz.ForwardBE, hz.ForwardAD, hz.ForwardBD,
            hz.StallF, hz.StallD, hz.StallE, hz.StallM,
            hz.FlushD, hz.FlushE, hz.FlushW, hz.mem_timeout};
  endfunction

  function automatic logic [13:0] mk(input logic [1:0] fae, input logic [1:0] fbe,
                                     input logic fad, input logic fbd,
                                     input logic [3:0] stalls, input logic [2:0] flushes,
                                     input logic to);
    return {fae, fbe, fad, fbd, stalls, flushes, to};
  endfunction

  task automatic clear_inputs();
    hz.rsD = 0; hz.rtD = 0; hz.rsE = 0; hz.rtE = 0;
    hz.WriteRegE = 0; hz.WriteRegM = 0; hz.WriteRegW = 0;
    hz.RegWriteE = 0; hz.RegWriteM = 0; hz.RegWriteW = 0;
    hz.MemtoRegE = 0; hz.MemtoRegM = 0;
    hz.BranchD = 0; hz.JumpD = 0; hz.PCSrcD = 0;
    hz.MemReqM = 0; hz.mem_ready = 0;
  endtask

  // Leaves the bench at posedge+1 with reset released and inputs idle.
  task automatic do_reset();
    clear_inputs();
    rst = 1'b0;
    @(posedge clka); @(posedge clka); #1;
    rst = 1'b1;
  endtask

  task automatic next_cycle();
    @(posedge clka); #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    clear_inputs();
    hz.rsE = 5; hz.rtE = 5; hz.WriteRegM = 5; hz.RegWriteM = 1;
    hz.rsD = 5; hz.MemReqM = 1; hz.mem_ready = 0; hz.JumpD = 1;
    @(posedge clka); @(negedge clka);
    total++;
    if (obs() !== 14'd0) begin
      bad++; $display("FAIL reset_outputs got=%b want=%b", obs(), 14'd0);
    end
    total++;
    if (hz.stall_cycles !== 32'd0 || hz.flush_cycles !== 32'd0) begin
      bad++; $display("FAIL reset_counters got=%0d/%0d want=0/0", hz.stall_cycles, hz.flush_cycles);
    end
    do_reset();
  endtask

  task automatic test_forward_e();
    clear_inputs();
    hz.rsE = 5; hz.rtE = 5; hz.WriteRegM = 5; hz.RegWriteM = 1;
    hz.WriteRegW = 5; hz.RegWriteW = 1;
    @(negedge clka);
    total++;
    if (obs() !== mk(2'b10, 2'b10, 0, 0, 4'b0, 3'b0, 0)) begin
      bad++; $display("FAIL fwd_m_beats_w got=%b want=%b", obs(), mk(2'b10, 2'b10, 0, 0, 4'b0, 3'b0, 0));
    end
    hz.RegWriteM = 0; #1;
    total++;
    if (obs() !== mk(2'b01, 2'b01, 0, 0, 4'b0, 3'b0, 0)) begin
      bad++; $display("FAIL fwd_w got=%b want=%b", obs(), mk(2'b01, 2'b01, 0, 0, 4'b0, 3'b0, 0));
    end
    hz.rsE = 0; hz.rtE = 0; hz.WriteRegW = 0; #1;
    total++;
    if (obs() !== 14'd0) begin
      bad++; $display("FAIL fwd_reg0 got=%b want=%b", obs(), 14'd0);
    end
    next_cycle();
  endtask

  task automatic test_lwstall();
    clear_inputs();
    hz.MemtoRegE = 1; hz.rtE = 8; hz.rsD = 8; hz.JumpD = 1;
    @(negedge clka);
    total++;
    if (obs() !== mk(0, 0, 0, 0, 4'b1100, 3'b010, 0)) begin
      bad++; $display("FAIL lwstall got=%b want=%b", obs(), mk(0, 0, 0, 0, 4'b1100, 3'b010, 0));
    end
    hz.rtE = 0; hz.rsD = 0; #1;
    total++;
    if (obs() !== mk(0, 0, 0, 0, 4'b0000, 3'b100, 0)) begin
      bad++; $display("FAIL lwstall_reg0_jump got=%b want=%b", obs(), mk(0, 0, 0, 0, 4'b0000, 3'b100, 0));
    end
    next_cycle();
  endtask

  task automatic test_branchstall();
    clear_inputs();
    hz.BranchD = 1; hz.RegWriteE = 1; hz.WriteRegE = 3; hz.rtD = 3; hz.PCSrcD = 1;
    @(negedge clka);
    total++;
    if (obs() !== mk(0, 0, 0, 0, 4'b1100, 3'b010, 0)) begin
      bad++; $display("FAIL branchstall_e got=%b want=%b", obs(), mk(0, 0, 0, 0, 4'b1100, 3'b010, 0));
    end
    next_cycle();
    hz.RegWriteE = 0; hz.WriteRegE = 0; hz.PCSrcD = 0;
    hz.WriteRegM = 3; hz.RegWriteM = 1; hz.MemtoRegM = 0;
    @(negedge clka);
    total++;
    if (obs() !== mk(0, 0, 0, 1, 4'b0000, 3'b000, 0)) begin
      bad++; $display("FAIL branch_fwd_bd got=%b want=%b", obs(), mk(0, 0, 0, 1, 4'b0000, 3'b000, 0));
    end
    hz.MemtoRegM = 1; #1;
    total++;
    if (obs() !== mk(0, 0, 0, 1, 4'b1100, 3'b010, 0)) begin
      bad++; $display("FAIL branchstall_load_m got=%b want=%b", obs(), mk(0, 0, 0, 1, 4'b1100, 3'b010, 0));
    end
    next_cycle();
  endtask

  task automatic test_mem_wait();
    clear_inputs();
    hz.MemReqM = 1; hz.mem_ready = 0;
    // load-use and jump coincident with the memory stall: memory wins
    hz.MemtoRegE = 1; hz.rtE = 9; hz.rsD = 9; hz.JumpD = 1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clka);
      total++;
      if (obs() !== mk(0, 0, 0, 0, 4'b1111, 3'b001, 0)) begin
        bad++; $display("FAIL memstall_cyc%0d got=%b want=%b", c, obs(), mk(0, 0, 0, 0, 4'b1111, 3'b001, 0));
      end
      next_cycle();
    end
    hz.mem_ready = 1;
    @(negedge clka);
    total++;
    if (obs() !== mk(0, 0, 0, 0, 4'b1100, 3'b010, 0)) begin
      bad++; $display("FAIL mem_done_lwstall got=%b want=%b", obs(), mk(0, 0, 0, 0, 4'b1100, 3'b010, 0));
    end
    next_cycle();
    clear_inputs();
    hz.MemReqM = 1; hz.mem_ready = 1;
    @(negedge clka);
    total++;
    if (obs() !== 14'd0) begin
      bad++; $display("FAIL mem_first_cycle_hit got=%b want=%b", obs(), 14'd0);
    end
    next_cycle();
  endtask

  task automatic test_timeout();
    clear_inputs();
    hz.MemReqM = 1; hz.mem_ready = 0;
    for (int e = 0; e < MAXW; e++) begin
      @(negedge clka);
      total++;
      if (obs() !== mk(0, 0, 0, 0, 4'b1111, 3'b001, 0)) begin
        bad++; $display("FAIL timeout_pre_edge%0d got=%b want=%b", e, obs(), mk(0, 0, 0, 0, 4'b1111, 3'b001, 0));
      end
      next_cycle();
    end
    hz.MemReqM = 0; hz.mem_ready = 1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clka);
      total++;
      if (obs() !== mk(0, 0, 0, 0, 4'b1111, 3'b001, 1)) begin
        bad++; $display("FAIL timeout_sticky%0d got=%b want=%b", c, obs(), mk(0, 0, 0, 0, 4'b1111, 3'b001, 1));
      end
      next_cycle();
    end
    #2 rst = 1'b0; #1;
    total++;
    if (obs() !== 14'd0) begin
      bad++; $display("FAIL timeout_async_reset got=%b want=%b", obs(), 14'd0);
    end
    next_cycle();
    rst = 1'b1;
    clear_inputs();
    @(negedge clka);
    total++;
    if (obs() !== 14'd0) begin
      bad++; $display("FAIL timeout_after_reset got=%b want=%b", obs(), 14'd0);
    end
    next_cycle();
  endtask

  task automatic test_perf_cnt();
    logic [31:0] want_s, want_f;
    do_reset();
    hz.MemReqM = 1; hz.mem_ready = 0;
    next_cycle(); next_cycle(); next_cycle();
    hz.mem_ready = 1; next_cycle();
    clear_inputs(); hz.JumpD = 1; next_cycle();
    clear_inputs(); next_cycle();
`ifdef HAZARD_PERF_CNT_EN
    want_s = 32'd3; want_f = 32'd4;
`else
    want_s = 32'd0; want_f = 32'd0;
`endif
    total++;
    if (hz.stall_cycles !== want_s) begin
      bad++; $display("FAIL perf_stall got=%0d want=%0d", hz.stall_cycles, want_s);
    end
    total++;
    if (hz.flush_cycles !== want_f) begin
      bad++; $display("FAIL perf_flush got=%0d want=%0d", hz.flush_cycles, want_f);
    end
  endtask

  // Reference: timeout after MAXW consecutive missed cycles; priority classes
  // memory > load/branch hazard > redirect; counters accumulate the class effects.
  function automatic logic hit(input logic [4:0] a, input logic [4:0] b, input logic we);
    return we && a != 0 && a == b;
  endfunction

  task automatic test_random();
    int run_m; bit err_m; longint sc_m, fc_m;
    logic [1:0] fae, fbe; logic fad, fbd; logic [3:0] st; logic [2:0] fl;
    logic [31:0] want_s, want_f;
    int cls;
    run_m = 0; err_m = 0; sc_m = 0; fc_m = 0;
    for (int n = 0; n < 1500; n++) begin
      if (n % 500 == 0) begin
        do_reset(); run_m = 0; err_m = 0; sc_m = 0; fc_m = 0;
      end
      hz.rsD = 5'($urandom_range(0, 3)); hz.rtD = 5'($urandom_range(0, 3));
      hz.rsE = 5'($urandom_range(0, 3)); hz.rtE = 5'($urandom_range(0, 3));
      hz.WriteRegE = 5'($urandom_range(0, 3)); hz.WriteRegM = 5'($urandom_range(0, 3));
      hz.WriteRegW = 5'($urandom_range(0, 3));
      hz.RegWriteE = 1'($urandom); hz.RegWriteM = 1'($urandom); hz.RegWriteW = 1'($urandom);
      hz.MemtoRegE = ($urandom_range(0, 3) == 0); hz.MemtoRegM = ($urandom_range(0, 3) == 0);
      hz.BranchD = 1'($urandom); hz.JumpD = ($urandom_range(0, 3) == 0);
      hz.PCSrcD = 1'($urandom);
      hz.MemReqM = 1'($urandom); hz.mem_ready = ($urandom_range(0, 3) != 0);

      fae = hit(hz.rsE, hz.WriteRegM, hz.RegWriteM) ? 2'b10 :
            hit(hz.rsE, hz.WriteRegW, hz.RegWriteW) ? 2'b01 : 2'b00;
      fbe = hit(hz.rtE, hz.WriteRegM, hz.RegWriteM) ? 2'b10 :
            hit(hz.rtE, hz.WriteRegW, hz.RegWriteW) ? 2'b01 : 2'b00;
      fad = hit(hz.rsD, hz.WriteRegM, hz.RegWriteM);
      fbd = hit(hz.rtD, hz.WriteRegM, hz.RegWriteM);
      if (err_m || (hz.MemReqM && !hz.mem_ready)) cls = 1;
      else if ((hz.MemtoRegE && (hit(hz.rsD, hz.rtE, 1) || hit(hz.rtD, hz.rtE, 1))) ||
               (hz.BranchD && (hit(hz.rsD, hz.WriteRegE, hz.RegWriteE) ||
                               hit(hz.rtD, hz.WriteRegE, hz.RegWriteE) ||
                               hit(hz.rsD, hz.WriteRegM, hz.MemtoRegM) ||
                               hit(hz.rtD, hz.WriteRegM, hz.MemtoRegM)))) cls = 2;
      else if (hz.PCSrcD || hz.JumpD) cls = 3;
      else cls = 0;
      case (cls)
        1: begin st = 4'b1111; fl = 3'b001; end
        2: begin st = 4'b1100; fl = 3'b010; end
        3: begin st = 4'b0000; fl = 3'b100; end
        default: begin st = 4'b0000; fl = 3'b000; end
      endcase

      @(negedge clka);
      total++;
      if (obs() !== mk(fae, fbe, fad, fbd, st, fl, err_m)) begin
        bad++; $display("FAIL rand_outputs n=%0d got=%b want=%b", n, obs(), mk(fae, fbe, fad, fbd, st, fl, err_m));
      end

      if (!err_m) begin
        if (hz.MemReqM && !hz.mem_ready) begin
          run_m++;
          if (run_m >= MAXW) err_m = 1;
        end else run_m = 0;
      end
      if (st[3] && sc_m < 64'hFFFF_FFFF) sc_m++;
      if (fl != 0 && fc_m < 64'hFFFF_FFFF) fc_m++;
      next_cycle();
`ifdef HAZARD_PERF_CNT_EN
      want_s = sc_m[31:0]; want_f = fc_m[31:0];
`else
      want_s = 32'd0; want_f = 32'd0;
`endif
      total++;
      if (hz.stall_cycles !== want_s || hz.flush_cycles !== want_f) begin
        bad++; $display("FAIL rand_counters n=%0d got=%0d/%0d want=%0d/%0d", n,
                        hz.stall_cycles, hz.flush_cycles, want_s, want_f);
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b0;
    clear_inputs();
    test_reset();
    test_forward_e();
    test_lwstall();
    test_branchstall();
    test_mem_wait();
    test_timeout();
    test_perf_cnt();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Pipeline hazard resolver for the five-stage MIPS core. It consumes the per-stage control signals (RegWriteE/M/W, MemtoRegE/M, BranchD, JumpD) and register specifiers that the controller and datapath produce. It returns forwarding selects plus stall and flush enables to the pipeline registers. It also tracks data-memory wait states with a small FSM that includes a sticky timeout, and optionally counts stall and flush cycles.

## Interface
- MAX_WAIT, 16: memory wait cycles tolerated before timeout (≥1).
- clka  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- rsD, rtD, rsE, rtE  in  5 each  source register numbers in D and E.
- WriteRegE, WriteRegM, WriteRegW  in  5 each  destination register per stage.
- RegWriteE, RegWriteM, RegWriteW  in  1 each  register write enable per stage.
- MemtoRegE, MemtoRegM  in  1 each  load in E / M.
- BranchD, JumpD, PCSrcD  in  1 each  branch in D, jump in D, branch taken.
- MemReqM  in  1  load/store active in M.
- mem_ready  in  1  data memory completes access this cycle.
- ForwardAE, ForwardBE  out  2 each  ALU operand select: 00 register file, 01 W result, 10 M ALU result.
- ForwardAD, ForwardBD  out  1 each  forward M ALU result to D comparator.
- StallF, StallD, StallE, StallM  out  1 each  hold pipeline register.
- FlushD, FlushE, FlushW  out  1 each  clear pipeline register.
- mem_timeout  out  1  sticky memory timeout error.
- stall_cycles, flush_cycles  out  32 each  performance counters (see Configuration).

## Operation
- Register 0 never matches for any forward or stall comparison.
- ForwardAE:
  - 10 if rsE==WriteRegM and RegWriteM.
  - Otherwise 01 if rsE==WriteRegW and RegWriteW.
  - Otherwise 00.
  - M beats W. ForwardBE is the same rule applied to rtE.
- ForwardAD = RegWriteM && rsD==WriteRegM. ForwardBD uses rtD.
- lwstall = MemtoRegE && (rtE==rsD || rtE==rtD).
- branchstall = BranchD && ((RegWriteE && WriteRegE∈{rsD,rtD}) || (MemtoRegM && WriteRegM∈{rsD,rtD})).
- memstall = (MemReqM && !mem_ready) || state==ERR.
- Memory wait FSM, states IDLE, WAIT, ERR:
  - IDLE → WAIT when MemReqM && !mem_ready; wait_cnt←1.
  - WAIT → IDLE when mem_ready; wait_cnt←0.
  - WAIT: if !mem_ready, wait_cnt+1. On reaching MAX_WAIT, go to ERR.
  - ERR is terminal until reset; mem_timeout=1 only in ERR.
  - MemReqM dropping while in WAIT (a flushed access) returns the FSM to IDLE.
- Output priority, first match wins:
  1. memstall: StallF=StallD=StallE=StallM=1, FlushW=1; FlushD=FlushE=0.
  2. lwstall or branchstall: StallF=StallD=1, FlushE=1.
  3. PCSrcD or JumpD: FlushD=1.
  - All outputs not named in the matching case are 0.

## Timing
- Forwards, stalls and flushes are combinational from the current inputs and FSM state; zero latency.
- The FSM and counters update on the rising edge of clka.
- Reset, while rst=0:
  - FSM goes to IDLE, wait_cnt=0, mem_timeout=0, counters 0.
  - All Stall*, Flush* and Forward* outputs are forced to 0.
- Reset asserted mid-WAIT or in ERR takes effect immediately; after release, the FSM starts in IDLE.
- An access with mem_ready high in its first M cycle causes no stall and no FSM transition.
- A load-use hazard coincident with memstall: memstall wins. The load-use stall re-evaluates after memory completes.
- A jump coincident with a load/branch stall: FlushD=0. The jump retires after the stall clears.

## Configuration
- HAZARD_PERF_CNT_EN defined:
  - stall_cycles increments each cycle StallF=1.
  - flush_cycles increments each cycle any Flush* is 1.
  - Both saturate at 32'hFFFFFFFF and are cleared by reset.
- HAZARD_PERF_CNT_EN undefined: the ports remain and are tied to 0; no counter flops.

## Structure
- Shared package mips_pkg holds:
  - forward select constants FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10;
  - FSM state encoding MW_IDLE, MW_WAIT, MW_ERR.
- Sub-module mem_wait_fsm: ports clka, rst, MemReqM, mem_ready → memstall, mem_timeout; parameter MAX_WAIT.
- Forwarding and stall logic stay in hazard_unit.

## Test plan
- rsE=5, WriteRegM=5, RegWriteM=1, and WriteRegW=5, RegWriteW=1 → ForwardAE=10. Drop RegWriteM → 01. Set rsE=0 → 00.
- MemtoRegE=1, rtE=8, rsD=8 → StallF=StallD=1, FlushE=1, StallE=0.
- BranchD=1, RegWriteE=1, WriteRegE=rtD=3 → branchstall asserted. Next cycle with the producer in M and MemtoRegM=0 → no stall, ForwardBD=1.
- MemReqM=1, mem_ready low 3 cycles then high, MAX_WAIT=16 → all four stalls and FlushW high for 3 cycles, FSM back in IDLE, mem_timeout=0.
- MemReqM=1, mem_ready held low, MAX_WAIT=4 → mem_timeout=1 after the 4th WAIT edge and stays with stalls held. rst pulse low → everything 0, FSM IDLE.
- With HAZARD_PERF_CNT_EN: 3-cycle memstall plus one jump → stall_cycles=3, flush_cycles=4. Without the macro → both 0.
